// File: rtl/cv32e40x_pkg.sv
// Shared constants for the register-file scoreboard.
// Holds the register-file geometry, the regfile forward-select code and
// the legal parameter ranges used to reject bad configurations at elaboration.
package cv32e40x_pkg;

  localparam int unsigned ADDR_W          = 5;
  localparam int unsigned NUM_REGS        = 32;

  // fw_sel value meaning "take operand from the register file"
  localparam int unsigned FW_SEL_REGFILE  = 0;

  localparam int unsigned READ_PORTS_MIN  = 1;
  localparam int unsigned READ_PORTS_MAX  = 3;
  localparam int unsigned RET_PORTS_MIN   = 1;
  localparam int unsigned RET_PORTS_MAX   = 4;
  localparam int unsigned MAX_PENDING_MIN = 1;
  localparam int unsigned MAX_PENDING_MAX = 7;

  // True when all scoreboard parameters lie in their supported ranges
  function automatic logic params_legal(input int unsigned read_ports,
                                        input int unsigned ret_ports,
                                        input int unsigned max_pending);
    return (read_ports  >= READ_PORTS_MIN)  && (read_ports  <= READ_PORTS_MAX) &&
           (ret_ports   >= RET_PORTS_MIN)   && (ret_ports   <= RET_PORTS_MAX)  &&
           (max_pending >= MAX_PENDING_MIN) && (max_pending <= MAX_PENDING_MAX);
  endfunction

endpackage

// File: rtl/cv32e40x_sb_counter.sv
// Pending-write counter for one architectural register.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   flush      : clear the counter; inc still loads a single new write
//   inc        : one new write issued to this register
//   dec        : number of writes retired/cancelled this cycle
//   cnt        : current number of outstanding writes
//   err        : sticky underflow/overflow flag, cleared only by reset
module cv32e40x_sb_counter #(
  parameter int unsigned MAX_PENDING = 3,
  parameter int unsigned CNT_W       = 2,
  parameter int unsigned DEC_W       = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             inc,
  input  logic [DEC_W-1:0] dec,
  output logic [CNT_W-1:0] cnt,
  output logic             err
);

  // Wide enough to hold cnt + inc and any dec without wrapping
  localparam int unsigned SUM_W = CNT_W + DEC_W + 1;

  logic [SUM_W-1:0] sum;
  logic [SUM_W-1:0] dec_w;
  logic [SUM_W-1:0] diff;
  logic [CNT_W-1:0] cnt_nxt;
  logic             err_nxt;

  // Net update with clamp on underflow and saturation on overflow
  always_comb begin
    sum     = SUM_W'(cnt) + SUM_W'(inc);
    dec_w   = SUM_W'(dec);
    diff    = sum - dec_w;
    cnt_nxt = cnt;
    err_nxt = err;
    if (flush) begin
      cnt_nxt = CNT_W'(inc);
    end else if (dec_w > sum) begin
      cnt_nxt = '0;
      err_nxt = 1'b1;
    end else if (diff > SUM_W'(MAX_PENDING)) begin
      cnt_nxt = CNT_W'(MAX_PENDING);
      err_nxt = 1'b1;
    end else begin
      cnt_nxt = CNT_W'(diff);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      err <= 1'b0;
    end else begin
      cnt <= cnt_nxt;
      err <= err_nxt;
    end
  end

endmodule

// File: rtl/cv32e40x_rf_scoreboard.sv
// Register-file scoreboard: per-register pending-write counters driving
// RAW/WAW stalls and operand forward selection for the ID stage.
// Ports:
//   issue_*          : ID->EX issue of a (possibly) register-writing instruction
//   ret_*            : per-port retire (commit) or cancel of an outstanding write
//   flush_i          : drop all pending state
//   rf_re_i/raddr_i  : ID read ports to check
//   rd_stall_o       : per read port RAW hazard
//   stall_o          : any read hazard or WAW saturation stall
//   issue_waw_stall_o: issuing destination already has MAX_PENDING writes
//   fw_sel_o         : per read port, 0 = regfile, k = retire port k-1
//   pending_any_o    : some register has an outstanding write
//   err_o            : sticky counter underflow/overflow
module cv32e40x_rf_scoreboard
  import cv32e40x_pkg::*;
#(
  parameter int unsigned REGFILE_NUM_READ_PORTS = 2,
  parameter int unsigned NUM_RET_PORTS          = 2,
  parameter int unsigned MAX_PENDING            = 3
) (
  input  logic                                                    clk,
  input  logic                                                    rst_n,
  input  logic                                                    issue_i,
  input  logic                                                    issue_rf_we_i,
  input  logic [ADDR_W-1:0]                                       issue_waddr_i,
  input  logic [NUM_RET_PORTS-1:0]                                ret_valid_i,
  input  logic [NUM_RET_PORTS-1:0]                                ret_commit_i,
  input  logic [ADDR_W*NUM_RET_PORTS-1:0]                         ret_waddr_i,
  input  logic                                                    flush_i,
  input  logic [REGFILE_NUM_READ_PORTS-1:0]                       rf_re_i,
  input  logic [ADDR_W*REGFILE_NUM_READ_PORTS-1:0]                rf_raddr_i,
  output logic [REGFILE_NUM_READ_PORTS-1:0]                       rd_stall_o,
  output logic                                                    stall_o,
  output logic                                                    issue_waw_stall_o,
  output logic [REGFILE_NUM_READ_PORTS*$clog2(NUM_RET_PORTS+1)-1:0] fw_sel_o,
  output logic                                                    pending_any_o,
  output logic                                                    err_o
);

  localparam int unsigned RP = REGFILE_NUM_READ_PORTS;
  localparam int unsigned CW = $clog2(MAX_PENDING + 1);
  localparam int unsigned DW = $clog2(NUM_RET_PORTS + 1);
  localparam int unsigned FW = DW;

  if (!params_legal(REGFILE_NUM_READ_PORTS, NUM_RET_PORTS, MAX_PENDING)) begin : g_param_err
    $error("cv32e40x_rf_scoreboard: parameter out of supported range");
  end

  logic [CW-1:0]          cnt [NUM_REGS];
  logic [DW-1:0]          dec [NUM_REGS];
  logic [NUM_REGS-1:1]    err_bits;
  logic                   inc_en;

  logic [ADDR_W-1:0]      rd_addr    [RP];
  logic [DW-1:0]          rd_ncommit [RP];
  logic [FW-1:0]          rd_sel     [RP];
  logic [RP-1:0]          multi_commit;

  assign cnt[0] = '0;

  // Retire reduction: how many ports retire each register this cycle
  always_comb begin
    for (int r = 0; r < NUM_REGS; r++) begin
      dec[r] = '0;
      for (int k = 0; k < NUM_RET_PORTS; k++) begin
        if (ret_valid_i[k] && (ret_waddr_i[k*ADDR_W +: ADDR_W] == ADDR_W'(r))) begin
          dec[r] = dec[r] + DW'(1);
        end
      end
    end
  end

  // A retire of the saturated register frees a slot in the same cycle
  assign issue_waw_stall_o = issue_rf_we_i && (issue_waddr_i != '0) &&
                             (cnt[issue_waddr_i] == CW'(MAX_PENDING)) &&
                             (dec[issue_waddr_i] == '0);

  assign inc_en = issue_i && issue_rf_we_i && !issue_waw_stall_o;

  for (genvar r = 1; r < NUM_REGS; r++) begin : g_cnt
    cv32e40x_sb_counter #(
      .MAX_PENDING (MAX_PENDING),
      .CNT_W       (CW),
      .DEC_W       (DW)
    ) u_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .flush (flush_i),
      .inc   (inc_en && (issue_waddr_i == ADDR_W'(r))),
      .dec   (dec[r]),
      .cnt   (cnt[r]),
      .err   (err_bits[r])
    );
  end

  // RAW hazard and forward select per read port
  always_comb begin
    rd_stall_o   = '0;
    fw_sel_o     = '0;
    multi_commit = '0;
    for (int i = 0; i < RP; i++) begin
      rd_addr[i]    = rf_raddr_i[i*ADDR_W +: ADDR_W];
      rd_ncommit[i] = '0;
      rd_sel[i]     = FW'(FW_SEL_REGFILE);
      // Highest-indexed committing port wins the select
      for (int k = 0; k < NUM_RET_PORTS; k++) begin
        if (ret_valid_i[k] && ret_commit_i[k] &&
            (ret_waddr_i[k*ADDR_W +: ADDR_W] == rd_addr[i])) begin
          rd_ncommit[i] = rd_ncommit[i] + DW'(1);
          rd_sel[i]     = FW'(k + 1);
        end
      end
      if (rf_re_i[i] && (rd_addr[i] != '0) && (cnt[rd_addr[i]] != '0)) begin
        // Only the last outstanding write can be bypassed
        if ((cnt[rd_addr[i]] == CW'(1)) && (rd_ncommit[i] != '0)) begin
          fw_sel_o[i*FW +: FW] = rd_sel[i];
          if (rd_ncommit[i] != DW'(1)) begin
            rd_stall_o[i]   = 1'b1;
            multi_commit[i] = 1'b1;
          end
        end else begin
          rd_stall_o[i] = 1'b1;
        end
      end
    end
  end

  assign stall_o = (|rd_stall_o) || issue_waw_stall_o;
  assign err_o   = |err_bits;

  // Any outstanding write anywhere
  always_comb begin
    pending_any_o = 1'b0;
    for (int r = 1; r < NUM_REGS; r++) begin
      if (cnt[r] != '0) begin
        pending_any_o = 1'b1;
      end
    end
  end

  // Two ports committing the single outstanding write of a read register
  a_no_multi_commit: assert property (@(posedge clk) disable iff (!rst_n) multi_commit == '0);

endmodule

// File: tb/tb_cv32e40x_rf_scoreboard.sv
module tb_cv32e40x_rf_scoreboard;

  localparam int RP   = 2;
  localparam int NR   = 2;
  localparam int MAXP = 3;
  localparam int FW   = 2;

  logic            clk;
  logic            rst_n;
  logic            issue_i;
  logic            issue_rf_we_i;
  logic [4:0]      issue_waddr_i;
  logic [NR-1:0]   ret_valid_i;
  logic [NR-1:0]   ret_commit_i;
  logic [5*NR-1:0] ret_waddr_i;
  logic            flush_i;
  logic [RP-1:0]   rf_re_i;
  logic [5*RP-1:0] rf_raddr_i;
  logic [RP-1:0]   rd_stall_o;
  logic            stall_o;
  logic            issue_waw_stall_o;
  logic [RP*FW-1:0] fw_sel_o;
  logic            pending_any_o;
  logic            err_o;

  int checks = 0;
  int errors = 0;

  cv32e40x_rf_scoreboard #(
    .REGFILE_NUM_READ_PORTS (RP),
    .NUM_RET_PORTS          (NR),
    .MAX_PENDING            (MAXP)
  ) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .issue_i           (issue_i),
    .issue_rf_we_i     (issue_rf_we_i),
    .issue_waddr_i     (issue_waddr_i),
    .ret_valid_i       (ret_valid_i),
    .ret_commit_i      (ret_commit_i),
    .ret_waddr_i       (ret_waddr_i),
    .flush_i           (flush_i),
    .rf_re_i           (rf_re_i),
    .rf_raddr_i        (rf_raddr_i),
    .rd_stall_o        (rd_stall_o),
    .stall_o           (stall_o),
    .issue_waw_stall_o (issue_waw_stall_o),
    .fw_sel_o          (fw_sel_o),
    .pending_any_o     (pending_any_o),
    .err_o             (err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       iss;  logic we;  logic [4:0] wa;
    logic [1:0] rv;   logic [1:0] rc; logic [4:0] ra0; logic [4:0] ra1;
    logic       fl;   logic [1:0] re; logic [4:0] rr0; logic [4:0] rr1;
    logic [1:0] e_rs; logic e_waw; logic [1:0] e_fw0; logic [1:0] e_fw1;
    logic       e_pend; logic e_err;
  } vec_t;

  vec_t vecs[$];

  // Reference model state: outstanding writes per register and sticky error
  int cnt_m [32];
  bit err_m;

  function automatic vec_t mk(logic iss, logic we, logic [4:0] wa, logic [1:0] rv, logic [1:0] rc,
                              logic [4:0] ra0, logic [4:0] ra1, logic fl, logic [1:0] re,
                              logic [4:0] rr0, logic [4:0] rr1, logic [1:0] e_rs, logic e_waw,
                              logic [1:0] e_fw0, logic [1:0] e_fw1, logic e_pend, logic e_err);
    vec_t v;
    v.iss = iss; v.we = we; v.wa = wa; v.rv = rv; v.rc = rc; v.ra0 = ra0; v.ra1 = ra1;
    v.fl = fl; v.re = re; v.rr0 = rr0; v.rr1 = rr1; v.e_rs = e_rs; v.e_waw = e_waw;
    v.e_fw0 = e_fw0; v.e_fw1 = e_fw1; v.e_pend = e_pend; v.e_err = e_err;
    return v;
  endfunction

  task automatic drive(input logic iss, input logic we, input logic [4:0] wa,
                       input logic [1:0] rv, input logic [1:0] rc,
                       input logic [4:0] ra0, input logic [4:0] ra1, input logic fl,
                       input logic [1:0] re, input logic [4:0] rr0, input logic [4:0] rr1);
    issue_i = iss; issue_rf_we_i = we; issue_waddr_i = wa;
    ret_valid_i = rv; ret_commit_i = rc; ret_waddr_i = {ra1, ra0};
    flush_i = fl; rf_re_i = re; rf_raddr_i = {rr1, rr0};
  endtask

  task automatic idle();
    drive(0, 0, 0, 2'b00, 2'b00, 0, 0, 0, 2'b00, 0, 0);
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [1:0] rs, input logic waw,
                         input int fw0, input int fw1, input logic pend, input logic err);
    chk({tag, "_rd_stall"}, int'(rd_stall_o), int'(rs));
    chk({tag, "_waw"}, int'(issue_waw_stall_o), int'(waw));
    chk({tag, "_stall"}, int'(stall_o), int'((rs != 2'b00) || waw));
    chk({tag, "_fw0"}, int'(fw_sel_o[1:0]), fw0);
    chk({tag, "_fw1"}, int'(fw_sel_o[3:2]), fw1);
    chk({tag, "_pend"}, int'(pending_any_o), int'(pend));
    chk({tag, "_err"}, int'(err_o), int'(err));
  endtask

  // Expected outputs of the current cycle from model state, then advance the model
  task automatic model_cycle(input string tag);
    int dec_m [32];
    int ncommit, sel, v, a, wa;
    logic [1:0] e_rs;
    int e_fw [2];
    bit e_waw, inc_ok;
    for (int r = 0; r < 32; r++) dec_m[r] = 0;
    for (int k = 0; k < NR; k++)
      if (ret_valid_i[k]) dec_m[ret_waddr_i[k*5 +: 5]]++;
    wa = int'(issue_waddr_i);
    e_waw = issue_rf_we_i && wa != 0 && cnt_m[wa] == MAXP && dec_m[wa] == 0;
    for (int i = 0; i < RP; i++) begin
      a = int'(rf_raddr_i[i*5 +: 5]);
      ncommit = 0; sel = 0; e_rs[i] = 1'b0; e_fw[i] = 0;
      for (int k = 0; k < NR; k++)
        if (ret_valid_i[k] && ret_commit_i[k] && int'(ret_waddr_i[k*5 +: 5]) == a) begin
          ncommit++; sel = k + 1;
        end
      if (rf_re_i[i] && a != 0 && cnt_m[a] > 0) begin
        if (cnt_m[a] == 1 && ncommit >= 1) begin
          e_fw[i] = sel;
          e_rs[i] = (ncommit > 1);
        end else begin
          e_rs[i] = 1'b1;
        end
      end
    end
    begin
      bit pend_m;
      pend_m = 0;
      for (int r = 1; r < 32; r++) if (cnt_m[r] != 0) pend_m = 1;
      chk_all(tag, e_rs, e_waw, e_fw[0], e_fw[1], pend_m, err_m);
    end
    inc_ok = issue_i && issue_rf_we_i && wa != 0 && !e_waw;
    if (flush_i) begin
      for (int r = 0; r < 32; r++) cnt_m[r] = 0;
      if (inc_ok) cnt_m[wa] = 1;
    end else begin
      for (int r = 1; r < 32; r++) begin
        v = cnt_m[r] + ((inc_ok && wa == r) ? 1 : 0) - dec_m[r];
        if (v < 0) begin v = 0; err_m = 1; end
        if (v > MAXP) begin v = MAXP; err_m = 1; end
        cnt_m[r] = v;
      end
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int a0, a1, tries;
    rst_n = 1'b0;
    idle();
    repeat (2) @(negedge clk);
    #1 chk_all("reset", 2'b00, 0, 0, 0, 0, 0);
    rst_n = 1'b1;

    //         iss we wa  rv     rc     ra0 ra1 fl re     rr0 rr1   rs     waw fw0 fw1 pend err
    vecs.push_back(mk(0, 0, 0, 2'b00, 2'b00, 0, 0, 0, 2'b11, 5, 5, 2'b00, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 1, 7, 2'b00, 2'b00, 0, 0, 0, 2'b10, 0, 7, 2'b00, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 2'b10, 2'b10, 0, 7, 0, 2'b10, 0, 7, 2'b00, 0, 0, 2, 1, 0));
    vecs.push_back(mk(0, 0, 0, 2'b00, 2'b00, 0, 0, 0, 2'b11, 7, 7, 2'b00, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 1, 3, 2'b00, 2'b00, 0, 0, 0, 2'b00, 0, 0, 2'b00, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 1, 3, 2'b00, 2'b00, 0, 0, 0, 2'b01, 3, 0, 2'b01, 0, 0, 0, 1, 0));
    vecs.push_back(mk(0, 0, 0, 2'b01, 2'b01, 3, 0, 0, 2'b01, 3, 0, 2'b01, 0, 0, 0, 1, 0));
    vecs.push_back(mk(0, 0, 0, 2'b10, 2'b10, 0, 3, 0, 2'b01, 3, 0, 2'b00, 0, 2, 0, 1, 0));
    vecs.push_back(mk(1, 1, 6, 2'b00, 2'b00, 0, 0, 0, 2'b00, 0, 0, 2'b00, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 2'b01, 2'b00, 6, 0, 0, 2'b10, 0, 6, 2'b10, 0, 0, 0, 1, 0));
    vecs.push_back(mk(0, 0, 0, 2'b00, 2'b00, 0, 0, 0, 2'b10, 0, 6, 2'b00, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 1, 9, 2'b00, 2'b00, 0, 0, 0, 2'b00, 0, 0, 2'b00, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 1, 9, 2'b00, 2'b00, 0, 0, 0, 2'b00, 0, 0, 2'b00, 0, 0, 0, 1, 0));
    vecs.push_back(mk(1, 1, 9, 2'b00, 2'b00, 0, 0, 0, 2'b00, 0, 0, 2'b00, 0, 0, 0, 1, 0));
    vecs.push_back(mk(1, 1, 9, 2'b00, 2'b00, 0, 0, 0, 2'b01, 9, 0, 2'b01, 1, 0, 0, 1, 0));
    vecs.push_back(mk(1, 1, 9, 2'b01, 2'b01, 9, 0, 0, 2'b00, 0, 0, 2'b00, 0, 0, 0, 1, 0));
    vecs.push_back(mk(1, 1, 9, 2'b00, 2'b00, 0, 0, 0, 2'b00, 0, 0, 2'b00, 1, 0, 0, 1, 0));
    vecs.push_back(mk(0, 0, 0, 2'b11, 2'b00, 9, 9, 0, 2'b00, 0, 0, 2'b00, 0, 0, 0, 1, 0));
    vecs.push_back(mk(0, 0, 0, 2'b10, 2'b10, 0, 9, 0, 2'b01, 9, 0, 2'b00, 0, 2, 0, 1, 0));
    vecs.push_back(mk(0, 0, 0, 2'b01, 2'b01, 4, 0, 0, 2'b10, 0, 4, 2'b00, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 2'b00, 2'b00, 0, 0, 0, 2'b00, 0, 0, 2'b00, 0, 0, 0, 0, 1));
    vecs.push_back(mk(0, 0, 0, 2'b00, 2'b00, 0, 0, 0, 2'b11, 4, 4, 2'b00, 0, 0, 0, 0, 1));
    vecs.push_back(mk(1, 1, 0, 2'b00, 2'b00, 0, 0, 0, 2'b11, 0, 0, 2'b00, 0, 0, 0, 0, 1));
    vecs.push_back(mk(0, 0, 0, 2'b00, 2'b00, 0, 0, 0, 2'b00, 0, 0, 2'b00, 0, 0, 0, 0, 1));
    vecs.push_back(mk(1, 0, 8, 2'b00, 2'b00, 0, 0, 0, 2'b00, 0, 0, 2'b00, 0, 0, 0, 0, 1));
    vecs.push_back(mk(0, 0, 0, 2'b00, 2'b00, 0, 0, 0, 2'b01, 8, 0, 2'b00, 0, 0, 0, 0, 1));

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      drive(vecs[i].iss, vecs[i].we, vecs[i].wa, vecs[i].rv, vecs[i].rc, vecs[i].ra0,
            vecs[i].ra1, vecs[i].fl, vecs[i].re, vecs[i].rr0, vecs[i].rr1);
      #1 chk_all($sformatf("vec%0d", i), vecs[i].e_rs, vecs[i].e_waw, int'(vecs[i].e_fw0),
                 int'(vecs[i].e_fw1), vecs[i].e_pend, vecs[i].e_err);
    end

    // Asynchronous reset in the middle of activity
    repeat (3) begin
      @(negedge clk);
      drive(1, 1, 5, 2'b00, 2'b00, 0, 0, 0, 2'b00, 0, 0);
    end
    @(negedge clk);
    drive(0, 0, 0, 2'b00, 2'b00, 0, 0, 0, 2'b11, 5, 5);
    #1 chk_all("pre_rst", 2'b11, 0, 0, 0, 1, 1);
    rst_n = 1'b0;
    #1 chk_all("in_rst", 2'b00, 0, 0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk_all("post_rst", 2'b00, 0, 0, 0, 0, 0);

    // Flush with every register pending and a same-cycle issue
    for (int r = 1; r < 32; r++) begin
      @(negedge clk);
      drive(1, 1, 5'(r), 2'b00, 2'b00, 0, 0, 0, 2'b00, 0, 0);
    end
    @(negedge clk);
    drive(0, 0, 0, 2'b00, 2'b00, 0, 0, 0, 2'b11, 0, 0);
    #1 chk_all("full_x0", 2'b00, 0, 0, 0, 1, 0);
    @(negedge clk);
    drive(1, 1, 2, 2'b11, 2'b00, 5, 5, 1, 2'b00, 0, 0);
    #1 chk_all("flush", 2'b00, 0, 0, 0, 1, 0);
    @(negedge clk);
    drive(0, 0, 0, 2'b10, 2'b10, 0, 2, 0, 2'b11, 2, 3);
    #1 chk_all("post_flush", 2'b00, 0, 2, 0, 1, 0);
    @(negedge clk);
    drive(0, 0, 0, 2'b00, 2'b00, 0, 0, 0, 2'b01, 0, 0);
    #1 chk_all("flush_drain", 2'b00, 0, 0, 0, 0, 0);

    // Randomized traffic against the reference model
    for (int r = 0; r < 32; r++) cnt_m[r] = 0;
    err_m = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      if (cyc % 400 == 399) begin
        idle();
        rst_n = 1'b0;
        #2 rst_n = 1'b1;
        for (int r = 0; r < 32; r++) cnt_m[r] = 0;
        err_m = 0;
        continue;
      end
      issue_i       = ($urandom_range(0, 99) < 50);
      issue_rf_we_i = ($urandom_range(0, 3) != 0);
      issue_waddr_i = 5'($urandom_range(0, 7));
      a0 = 0; a1 = 0;
      for (int k = 0; k < NR; k++) begin
        int a;
        a = $urandom_range(0, 7);
        tries = 0;
        while (cnt_m[a] == 0 && tries < 8 && $urandom_range(0, 9) != 0) begin
          a = $urandom_range(1, 7);
          tries++;
        end
        if (k == 0) a0 = a; else a1 = a;
      end
      if (a1 == a0) a1 = (a0 + 1 + $urandom_range(0, 6)) % 8;
      ret_valid_i  = NR'({$urandom_range(0, 99) < 35, $urandom_range(0, 99) < 35});
      ret_commit_i = NR'($urandom_range(0, 3));
      ret_waddr_i  = {5'(a1), 5'(a0)};
      flush_i      = ($urandom_range(0, 99) < 3);
      rf_re_i      = RP'($urandom_range(0, 3));
      rf_raddr_i   = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
      #1 model_cycle($sformatf("rand%0d", cyc));
    end

    @(negedge clk);
    idle();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
